// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    // Queue entries are sized for the widest supported PC and instruction.
    localparam int unsigned PC_W       = 32;
    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned INSTR_STEP = 4;
    localparam int unsigned WORD_SHIFT = 2;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue with push/pop/flush; push and pop may coincide at any occupancy.
import fetch_pkg::*;

module fetch_queue #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  fetch_entry_t       push_entry,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t       mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    // Pointer and occupancy tracking; flush wins over push/pop.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_entry;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC, one-cycle memory reads, branch redirect, decode queue.
// Optional performance counters are built when FETCH_PERF_EN is defined.
import fetch_pkg::*;

module fetch_unit #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        DATA_W   = 32,
    parameter int unsigned        Q_DEPTH  = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              br_taken,
    input  logic              br_abs,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [15:0]       br_rel,
    input  logic [ADDR_W-1:0] br_base,
    input  logic [15:0]       br_off,
    output logic              im_rd_en,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [DATA_W-1:0] im_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch,
    output logic [31:0]       perf_redirect
`endif
);

    localparam int unsigned CNT_W = $clog2(Q_DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(INSTR_STEP - 1);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic [ADDR_W-1:0] rel_off;
    logic [ADDR_W-1:0] abs_off;
    logic [ADDR_W-1:0] target;
    logic [CNT_W-1:0]  q_count;
    logic [OCC_W-1:0]  occupancy;
    logic              issue;
    logic              push;
    logic              pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    // Redirect target, word aligned.
    always_comb begin
        rel_off = ADDR_W'($signed(br_rel)) << WORD_SHIFT;
        abs_off = ADDR_W'($signed(br_off));
        target  = (br_abs ? (br_base + abs_off) : (br_pc + rel_off)) & ALIGN_MASK;
    end

    // A read is only issued when its response is guaranteed a queue slot.
    assign occupancy = OCC_W'(q_count) + OCC_W'(inflight);
    assign issue     = rst_n && !br_taken && (occupancy < OCC_W'(Q_DEPTH));
    assign push      = inflight && !br_taken;
    assign pop       = if_valid && if_ready;

    assign push_entry.pc    = PC_W'(inflight_pc);
    assign push_entry.instr = INSTR_W'(im_rdata);

    // Issue with br_taken low means a redirect also kills the outstanding read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC & ALIGN_MASK;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            if (br_taken)   fetch_pc <= target;
            else if (issue) fetch_pc <= fetch_pc + ADDR_W'(INSTR_STEP);
            inflight <= issue;
            if (issue) inflight_pc <= fetch_pc;
        end
    end

    fetch_queue #(
        .DEPTH      (Q_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (br_taken),
        .head       (head),
        .count      (q_count)
    );

    assign im_rd_en = issue;
    assign im_addr  = fetch_pc;
    assign if_valid = (q_count != '0);
    assign if_pc    = if_valid ? ADDR_W'(head.pc)    : '0;
    assign if_instr = if_valid ? DATA_W'(head.instr) : '0;

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch    <= '0;
            perf_redirect <= '0;
        end else begin
            if (pop)      perf_fetch    <= perf_fetch + 32'd1;
            if (br_taken) perf_redirect <= perf_redirect + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency instruction memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br_taken;
    logic        br_abs;
    logic [31:0] br_pc;
    logic [15:0] br_rel;
    logic [31:0] br_base;
    logic [15:0] br_off;
    logic        im_rd_en;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_redirect;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_reads;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .Q_DEPTH  (4),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .br_taken      (br_taken),
        .br_abs        (br_abs),
        .br_pc         (br_pc),
        .br_rel        (br_rel),
        .br_base       (br_base),
        .br_off        (br_off),
        .im_rd_en      (im_rd_en),
        .im_addr       (im_addr),
        .im_rdata      (im_rdata),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch    (perf_fetch),
        .perf_redirect (perf_redirect)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    always @(posedge clk) begin
        if (im_rd_en) im_rdata <= mem_word(im_addr);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        br_taken = 1'b0;
        br_abs   = 1'b0;
        br_pc    = '0;
        br_rel   = '0;
        br_base  = '0;
        br_off   = '0;
        if_ready = 1'b1;
        im_rdata = '0;
        repeat (3) tick();

        check("rst_if_valid", if_valid, 1'b0);
        check("rst_if_pc",    if_pc,    32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_rd_en",    im_rd_en, 1'b0);

        // Reset release and sequential fetch.
        rst_n = 1'b1;
        #1;
        check("boot_rd_en", im_rd_en, 1'b1);
        check("boot_addr0", im_addr,  32'h100);
        tick();
        check("boot_addr1", im_addr,  32'h104);
        check("boot_nvalid", if_valid, 1'b0);
        tick();
        check("boot_valid", if_valid, 1'b1);
        check("boot_pc0",   if_pc,    32'h100);
        check("boot_ins0",  if_instr, mem_word(32'h100));
        tick();
        check("stream_pc1",   if_pc,   32'h104);
        check("stream_addr3", im_addr, 32'h10C);

        // Back-pressure: queue fills with exactly four reads, then drains in order.
        rst_n    = 1'b0;
        if_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        n_reads = 0;
        for (int i = 0; i < 8; i++) begin
            if (im_rd_en) n_reads++;
            tick();
        end
        check("full_reads",  n_reads,  4);
        check("full_rd_en",  im_rd_en, 1'b0);
        check("full_head",   if_pc,    32'h100);
        if_ready = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check("drain_pc",  if_pc,    32'h100 + 32'(4 * i));
            check("drain_ins", if_instr, mem_word(32'h100 + 32'(4 * i)));
            tick();
        end

        // Relative redirect while queued and in-flight entries exist.
        br_taken = 1'b1;
        br_abs   = 1'b0;
        br_pc    = 32'h200;
        br_rel   = 16'hFFFE;
        #1;
        check("rel_no_issue", im_rd_en, 1'b0);
        tick();
        br_taken = 1'b0;
        #1;
        check("rel_flushed", if_valid, 1'b0);
        check("rel_rd_en",   im_rd_en, 1'b1);
        check("rel_addr",    im_addr,  32'h1F8);
        tick();
        check("rel_killed",  if_valid, 1'b0);
        check("rel_addr1",   im_addr,  32'h1FC);
        tick();
        check("rel_valid",   if_valid, 1'b1);
        check("rel_head",    if_pc,    32'h1F8);

        // Absolute redirect with misaligned sum.
        br_taken = 1'b1;
        br_abs   = 1'b1;
        br_base  = 32'h1003;
        br_off   = 16'h0010;
        tick();
        br_taken = 1'b0;
        #1;
        check("abs_addr", im_addr, 32'h1010);
        repeat (2) tick();
        check("abs_head", if_pc, 32'h1010);

        // Address wrap at the top of the space.
        br_taken = 1'b1;
        br_base  = 32'hFFFF_FFFC;
        br_off   = 16'h0000;
        tick();
        br_taken = 1'b0;
        #1;
        check("wrap_addr_top", im_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr_zero", im_addr, 32'h0);
        tick();
        check("wrap_head_top", if_pc, 32'hFFFF_FFFC);
        tick();
        check("wrap_head_zero", if_pc, 32'h0);

        // Redirect coinciding with a decode handshake on a full queue.
        rst_n    = 1'b0;
        if_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
`ifdef FETCH_PERF_EN
        check("perf_fetch_rst",    perf_fetch,    32'd0);
        check("perf_redirect_rst", perf_redirect, 32'd0);
`endif
        repeat (6) tick();
        check("hs_full_rd_en", im_rd_en, 1'b0);
        check("hs_full_head",  if_pc,    32'h100);
        br_taken = 1'b1;
        br_abs   = 1'b1;
        br_base  = 32'h300;
        br_off   = 16'h0000;
        if_ready = 1'b1;
        tick();
        br_taken = 1'b0;
        #1;
        check("hs_flushed", if_valid, 1'b0);
        check("hs_addr",    im_addr,  32'h300);
`ifdef FETCH_PERF_EN
        check("hs_perf_fetch",    perf_fetch,    32'd1);
        check("hs_perf_redirect", perf_redirect, 32'd1);
`endif
        repeat (2) tick();
        check("hs_new_head", if_pc, 32'h300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
